// File: rtl/mul_pkg.sv
// Shared cherry-float constants for Mul users, arbiters and benches.
package mul_pkg;

  localparam int EXPONENT    = 8;
  localparam int BIAS        = 127;
  localparam int CF_MANTISSA = 9;
  localparam int CF_WIDTH    = CF_MANTISSA + EXPONENT + 1;

  localparam logic [CF_WIDTH-1:0] ONE     = 18'h0FE00;
  localparam logic [CF_WIDTH-1:0] ZERO    = 18'h00000;
  localparam logic [CF_WIDTH-1:0] QNAN    = 18'h3FF00;
  localparam logic [CF_WIDTH-1:0] POS_INF = 18'h1FE00;

endpackage

// File: rtl/Mul.sv
// Combinational cherry-float multiplier: flush-to-zero, truncating,
// saturates to inf on overflow and to signed zero on underflow.
module Mul
  import mul_pkg::*;
#(
  parameter int MANTISSA = CF_MANTISSA,
  localparam int WIDTH   = MANTISSA + EXPONENT + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int PW = 2 * (MANTISSA + 1);
  localparam int EW = EXPONENT + 3;
  localparam logic [EW-1:0] EXP_ONES = EW'((1 << EXPONENT) - 1);

  logic                sign;
  logic [EXPONENT-1:0] ea, eb;
  logic [MANTISSA-1:0] ma, mb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]       fa, fb, prod;
  logic                norm;
  logic [MANTISSA-1:0] mant;
  logic [EW-1:0]       exp_sum;
  logic                overflow, underflow;
  logic                unused_prod_bits;

  assign sign   = a[WIDTH-1] ^ b[WIDTH-1];
  assign ea     = a[WIDTH-2 -: EXPONENT];
  assign eb     = b[WIDTH-2 -: EXPONENT];
  assign ma     = a[MANTISSA-1:0];
  assign mb     = b[MANTISSA-1:0];

  // Denormals are flushed: a zero exponent means zero regardless of mantissa.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  assign fa     = {{(MANTISSA + 1){1'b0}}, 1'b1, ma};
  assign fb     = {{(MANTISSA + 1){1'b0}}, 1'b1, mb};
  assign prod   = fa * fb;

  // Product of two [1,2) values lies in [1,4); top bit selects the renormalise shift.
  assign norm   = prod[PW-1];
  assign mant   = norm ? prod[PW-2 -: MANTISSA] : prod[PW-3 -: MANTISSA];
  assign unused_prod_bits = &prod[MANTISSA-1:0];

  assign exp_sum   = EW'(ea) + EW'(eb) + EW'(norm) - EW'(BIAS);
  assign underflow = exp_sum[EW-1] || (exp_sum == '0);
  assign overflow  = !exp_sum[EW-1] && (exp_sum >= EXP_ONES);

  // Special-value resolution in priority order, then the normal product.
  always_comb begin
    y = {sign, exp_sum[EXPONENT-1:0], mant};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      y = {1'b1, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA - 1){1'b0}}};
    else if (a_inf || b_inf || overflow)
      y = {sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    else if (a_zero || b_zero || underflow)
      y = {sign, {(WIDTH - 1){1'b0}}};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at rr_ptr, pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_EXT = (PW + 1)'(N);

  logic [PW-1:0] rr_ptr_reg;
  logic [PW-1:0] rot_idx;
  logic [PW-1:0] grant_idx;
  logic [N-1:0]  req_rot;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [PW-1:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[PW-1:0];
  endfunction

  // Rotate requests so that rr_ptr lands at position 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign req_rot[gi] = req[wrap_add(rr_ptr_reg, PW'(gi))];
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_rot[i]) rot_idx = PW'(i);
  end

  assign grant_idx = wrap_add(rr_ptr_reg, rot_idx);

  // Un-rotate into a one-hot grant; nothing is granted while in reset.
  always_comb begin
    grant = '0;
    if (!reset && (req != '0)) grant[grant_idx] = 1'b1;
  end

  // Pointer advances to the slot after the winner on each accepted grant.
  always_ff @(posedge clk) begin
    if (reset)    rr_ptr_reg <= '0;
    else if (adv) rr_ptr_reg <= wrap_add(grant_idx, PW'(1));
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one Mul among NUM_REQ requesters through a tagged fixed-latency pipe.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MANTISSA = CF_MANTISSA,
  parameter int LATENCY  = 2,
  localparam int WIDTH   = MANTISSA + EXPONENT + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic             issue;
  logic [TAG_W-1:0] issue_tag;
  logic [WIDTH-1:0] issue_a, issue_b;
  logic [WIDTH-1:0] s1_a_reg, s1_b_reg;
  logic [WIDTH-1:0] product;
  logic [LATENCY:1] valid_reg;
  logic [TAG_W-1:0] tag_reg  [1:LATENCY];
  logic [WIDTH-1:0] data_reg [2:LATENCY];

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .adv   (issue),
    .grant (req_ready)
  );

  assign issue = |(req_valid & req_ready);

  // Encode the one-hot grant into a tag and select that requester's operands.
  always_comb begin
    issue_tag = '0;
    issue_a   = '0;
    issue_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        issue_tag = TAG_W'(i);
        issue_a   = req_a[i*WIDTH +: WIDTH];
        issue_b   = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  Mul #(.MANTISSA(MANTISSA)) u_mul (
    .a (s1_a_reg),
    .b (s1_b_reg),
    .y (product)
  );

  // Stage 1 captures operands on issue; later stages shift product, tag and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      s1_a_reg  <= '0;
      s1_b_reg  <= '0;
      for (int k = 1; k <= LATENCY; k++) tag_reg[k] <= '0;
      for (int k = 2; k <= LATENCY; k++) data_reg[k] <= '0;
    end else begin
      valid_reg   <= {valid_reg[LATENCY-1:1], issue};
      data_reg[2] <= product;
      for (int k = 3; k <= LATENCY; k++) data_reg[k] <= data_reg[k-1];
      for (int k = 2; k <= LATENCY; k++) tag_reg[k] <= tag_reg[k-1];
      if (issue) begin
        s1_a_reg   <= issue_a;
        s1_b_reg   <= issue_b;
        tag_reg[1] <= issue_tag;
      end
    end
  end

  // Route the last-stage valid to the tagged requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
    assign resp_valid[gi] = valid_reg[LATENCY] && (tag_reg[LATENCY] == TAG_W'(gi));
  end

  assign resp_data = data_reg[LATENCY];
  assign busy      = |valid_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: grants, latency, arithmetic, reset, specials.
module tb_mul_arbiter;
  import mul_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 2;
  localparam int W       = CF_WIDTH;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W-1:0]         resp_data;
  logic                 busy;

  int check_count = 0;
  int pass_count  = 0;

  logic [W-1:0] rr_b [NUM_REQ];

  mul_arbiter #(.NUM_REQ(NUM_REQ), .MANTISSA(CF_MANTISSA), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per delivered result.
  always @(negedge clk)
    if (resp_valid != '0)
      $display("resp: valid=%b data=%h", resp_valid, resp_data);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      pass_count++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rr_b[0] = 18'h10000;
    rr_b[1] = 18'h10100;
    rr_b[2] = 18'h0FF00;
    rr_b[3] = ONE;
    step(); step(); step();
    check_eq("ready_in_reset", 32'(req_ready), 32'h0);

    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_data", 32'(resp_data), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    step();

    // Single requester, 1.0 * 2.0
    req_valid = 4'b0001;
    set_op(0, ONE, 18'h10000);
    #1;
    check_eq("t1_ready", 32'(req_ready), 32'b0001);
    check_eq("t1_busy_idle", 32'(busy), 32'h0);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t1_busy_s1", 32'(busy), 32'h1);
    check_eq("t1_no_early_resp", 32'(resp_valid), 32'h0);
    step();
    check_eq("t1_resp_valid", 32'(resp_valid), 32'b0001);
    check_eq("t1_resp_data", 32'(resp_data), 32'h10000);
    check_eq("t1_busy_s2", 32'(busy), 32'h1);
    step();
    check_eq("t1_resp_done", 32'(resp_valid), 32'h0);
    check_eq("t1_busy_done", 32'(busy), 32'h0);

    // Arithmetic pass-through on requester 2
    req_valid = 4'b0100;
    set_op(2, 18'h10000, 18'h10100);
    #1;
    check_eq("t2_ready_a", 32'(req_ready), 32'b0100);
    step();
    set_op(2, 18'h0FF00, 18'h0FF00);
    #1;
    check_eq("t2_ready_b", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t2_valid_6", 32'(resp_valid), 32'b0100);
    check_eq("t2_data_6", 32'(resp_data), 32'h10300);
    step();
    check_eq("t2_valid_225", 32'(resp_valid), 32'b0100);
    check_eq("t2_data_225", 32'(resp_data), 32'h10040);
    step();

    // Pointer resume: 3 wraps pointer to 0, then 1010 alternates 1,3,1
    req_valid = 4'b1000;
    #1;
    check_eq("t3_ready_3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1010;
    #1;
    check_eq("t3_ready_1a", 32'(req_ready), 32'b0010);
    step();
    check_eq("t3_ready_3b", 32'(req_ready), 32'b1000);
    check_eq("t3_resp_3", 32'(resp_valid), 32'b1000);
    step();
    check_eq("t3_ready_1b", 32'(req_ready), 32'b0010);
    check_eq("t3_resp_1a", 32'(resp_valid), 32'b0010);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t3_resp_3b", 32'(resp_valid), 32'b1000);
    step();
    check_eq("t3_resp_1b", 32'(resp_valid), 32'b0010);
    step();

    // Pointer is at 2: grant 3 to bring it back to 0, then drain
    req_valid = 4'b1000;
    #1;
    check_eq("t4_ready_pre", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b0000;
    step(); step();

    // Round robin with everyone valid: products equal b since a = 1.0
    for (int i = 0; i < NUM_REQ; i++) set_op(i, ONE, rr_b[i]);
    for (int c = 0; c < 8 + LATENCY; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      check_eq($sformatf("t4_ready_c%0d", c), 32'(req_ready),
               (c < 8) ? (32'h1 << (c % NUM_REQ)) : 32'h0);
      if (c >= LATENCY) begin
        check_eq($sformatf("t4_resp_c%0d", c), 32'(resp_valid),
                 32'h1 << ((c - LATENCY) % NUM_REQ));
        check_eq($sformatf("t4_data_c%0d", c), 32'(resp_data),
                 32'(rr_b[(c - LATENCY) % NUM_REQ]));
      end
      step();
    end

    // Reset mid-flight discards in-flight ops and restarts the pointer
    req_valid = 4'b0001;
    #1;
    check_eq("t5_ready_0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0010;
    #1;
    check_eq("t5_ready_1", 32'(req_ready), 32'b0010);
    step();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check_eq("t5_ready_reset", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check_eq("t5_resp_after_rst", 32'(resp_valid), 32'h0);
    check_eq("t5_busy_after_rst", 32'(busy), 32'h0);
    check_eq("t5_ready_restart", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t5_resp_quiet", 32'(resp_valid), 32'h0);
    check_eq("t5_busy_new", 32'(busy), 32'h1);
    step();
    check_eq("t5_resp_new", 32'(resp_valid), 32'b0001);
    check_eq("t5_data_new", 32'(resp_data), 32'h10000);
    step();

    // Special values on requester 1
    req_valid = 4'b0010;
    set_op(1, POS_INF, ZERO);
    #1;
    check_eq("t6_ready_a", 32'(req_ready), 32'b0010);
    step();
    set_op(1, ONE, ZERO);
    #1;
    check_eq("t6_ready_b", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    #1;
    check_eq("t6_valid_nan", 32'(resp_valid), 32'b0010);
    check_eq("t6_data_nan", 32'(resp_data), 32'(QNAN));
    step();
    check_eq("t6_valid_zero", 32'(resp_valid), 32'b0010);
    check_eq("t6_data_zero", 32'(resp_data), 32'(ZERO));
    step();
    check_eq("t6_idle_valid", 32'(resp_valid), 32'h0);
    check_eq("t6_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
